// File: rtl/stream_demux_1ton_pkg.sv
// ============================================================================
// demux_pkg : shared defaults, slot state type and select range helper
// Revision  : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_NUM_CH = 32;
   localparam int DEFAULT_CNT_W  = 16;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   function automatic logic sel_in_range(input int sel, input int num_ch);
      return (sel < num_ch);
   endfunction

endpackage

`default_nettype wire

// File: rtl/stream_demux_1ton_if.sv
// ============================================================================
// stream_demux_1ton_if : producer side and NUM_CH sink sides of the demux
// Revision             : 1.0   (bcast_i present only with DEMUX_BCAST_EN)
// ============================================================================
`default_nettype none

interface stream_demux_1ton_if
   import demux_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int NUM_CH = DEFAULT_NUM_CH,
   parameter int CNT_W  = DEFAULT_CNT_W
);
   localparam int SEL_W = $clog2(NUM_CH);

   logic                     en_i;
   logic                     flush_i;
   logic                     valid_i;
   logic                     ready_o;
   logic [DATA_W-1:0]        data_i;
   logic [SEL_W-1:0]         sel_i;
`ifdef DEMUX_BCAST_EN
   logic                     bcast_i;
`endif
   logic [NUM_CH-1:0]        valid_o;
   logic [NUM_CH-1:0]        ready_i;
   logic [NUM_CH*DATA_W-1:0] data_o;
   logic                     err_o;
   logic [CNT_W-1:0]         drop_cnt_o;
   logic                     busy_o;

   modport slave (
`ifdef DEMUX_BCAST_EN
      input  bcast_i,
`endif
      input  en_i, flush_i, valid_i, data_i, sel_i, ready_i,
      output ready_o, valid_o, data_o, err_o, drop_cnt_o, busy_o
   );

   modport master (
`ifdef DEMUX_BCAST_EN
      output bcast_i,
`endif
      output en_i, flush_i, valid_i, data_i, sel_i, ready_i,
      input  ready_o, valid_o, data_o, err_o, drop_cnt_o, busy_o
   );

endinterface

`default_nettype wire

// File: rtl/stream_demux_1ton_slot.sv
// ============================================================================
// demux_slot : one-entry output register with load, drain and flush
// Revision   : 1.0
// ============================================================================
`default_nettype none

module demux_slot
   import demux_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  wire logic              clk_i,
   input  wire logic              rst_ni,
   input  wire logic              load,
   input  wire logic              drain,
   input  wire logic              flush,
   input  wire logic [DATA_W-1:0] din,
   output logic                   valid,
   output logic                   free,
   output logic [DATA_W-1:0]      dout
);

   slot_state_t       state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // Data returns to zero whenever the slot empties, so an idle channel reads 0.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      if (flush) begin
         state_d = SLOT_EMPTY;
         data_d  = '0;
      end else if (load) begin
         state_d = SLOT_FULL;
         data_d  = din;
      end else if ((state_q == SLOT_FULL) && drain) begin
         state_d = SLOT_EMPTY;
         data_d  = '0;
      end
   end

   assign valid = (state_q == SLOT_FULL);
   assign free  = !valid || drain;
   assign dout  = data_q;

endmodule

`default_nettype wire

// File: rtl/stream_demux_1ton.sv
// ============================================================================
// stream_demux_1ton : 1-to-NUM_CH valid/ready demux, one registered slot/channel
// Revision          : 1.0   (broadcast mode enabled by DEMUX_BCAST_EN)
// ============================================================================
`default_nettype none

module stream_demux_1ton
   import demux_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int NUM_CH = DEFAULT_NUM_CH,
   parameter int CNT_W  = DEFAULT_CNT_W
) (
   input  wire logic         clk_i,
   input  wire logic         rst_ni,
   stream_demux_1ton_if.slave bus
);

   localparam int SEL_W = $clog2(NUM_CH);
   localparam int SEL_N = 1 << SEL_W;

   logic [NUM_CH-1:0]        free;
   logic [NUM_CH-1:0]        load;
   logic [NUM_CH-1:0]        valid;
   logic [SEL_N-1:0]         free_ext;
   logic [NUM_CH*DATA_W-1:0] data_flat;
   logic                     bcast;
   logic                     in_range;
   logic                     ready;
   logic                     accept;
   logic                     drop;
   logic                     err_q;
   logic [CNT_W-1:0]         cnt_q;

`ifdef DEMUX_BCAST_EN
   assign bcast = bus.bcast_i;
`else
   assign bcast = 1'b0;
`endif

   assign in_range = sel_in_range(int'(bus.sel_i), NUM_CH);

   // free is padded to the full select range so any sel_i indexes safely.
   always_comb begin
      free_ext             = '0;
      free_ext[NUM_CH-1:0] = free;
      ready                = 1'b0;
      if (!bus.flush_i && bus.en_i) begin
         if (bcast)
            ready = &free;
         else if (!in_range)
            ready = 1'b1;
         else
            ready = free_ext[bus.sel_i];
      end
   end

   assign accept = bus.valid_i && ready;
   assign drop   = accept && !bcast && !in_range;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
      assign load[c] = accept && (bcast || (in_range && (bus.sel_i == SEL_W'(c))));

      demux_slot #(
         .DATA_W (DATA_W)
      ) u_slot (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .load   (load[c]),
         .drain  (bus.ready_i[c]),
         .flush  (bus.flush_i),
         .din    (bus.data_i),
         .valid  (valid[c]),
         .free   (free[c]),
         .dout   (data_flat[c*DATA_W +: DATA_W])
      );
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         err_q <= drop;
         if (drop && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.ready_o    = ready;
   assign bus.valid_o    = valid;
   assign bus.data_o     = data_flat;
   assign bus.err_o      = err_q;
   assign bus.drop_cnt_o = cnt_q;
   assign bus.busy_o     = |valid;

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_1ton.sv
// ============================================================================
// tb_stream_demux_1ton : vector table, corner sequences and random model check
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_stream_demux_1ton;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stream_demux_1ton_if #(.DATA_W(8), .NUM_CH(32), .CNT_W(16)) ifa ();
   stream_demux_1ton_if #(.DATA_W(8), .NUM_CH(20), .CNT_W(2))  ifb ();

   stream_demux_1ton #(.DATA_W(8), .NUM_CH(32), .CNT_W(16)) dut_a (
      .clk_i (clk), .rst_ni (rst_n), .bus (ifa));
   stream_demux_1ton #(.DATA_W(8), .NUM_CH(20), .CNT_W(2)) dut_b (
      .clk_i (clk), .rst_ni (rst_n), .bus (ifb));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       en;
      logic [4:0] sel;
      logic [7:0] data;
      logic       exp_rdy;
      logic [31:0] exp_vld;
      logic [7:0] exp_slice;
   } vec_t;

   vec_t vecs[8];

   // reference model state for channel-limited instance B
   logic       mv[20];
   logic [7:0] md[20];
   int         mcnt;
   logic       merr;

   initial begin
      logic [255:0] ed;
      logic [19:0]  evv;
      logic [159:0] evd;
      logic         r_en, r_fl, r_vl, exp_rdy, acc;
      logic [4:0]   r_sel;
      logic [7:0]   r_dat;
      logic [19:0]  r_rdy;

      ifa.en_i = 1'b1; ifa.flush_i = 1'b0; ifa.valid_i = 1'b0;
      ifa.data_i = '0; ifa.sel_i = '0; ifa.ready_i = '1;
      ifb.en_i = 1'b1; ifb.flush_i = 1'b0; ifb.valid_i = 1'b0;
      ifb.data_i = '0; ifb.sel_i = '0; ifb.ready_i = '1;
`ifdef DEMUX_BCAST_EN
      ifa.bcast_i = 1'b0;
      ifb.bcast_i = 1'b0;
`endif

      vecs[0] = '{1'b1, 5'd3,  8'hA5, 1'b1, 32'h0000_0008, 8'hA5};
      vecs[1] = '{1'b1, 5'd0,  8'h01, 1'b1, 32'h0000_0001, 8'h01};
      vecs[2] = '{1'b1, 5'd31, 8'hFF, 1'b1, 32'h8000_0000, 8'hFF};
      vecs[3] = '{1'b1, 5'd31, 8'h7E, 1'b1, 32'h8000_0000, 8'h7E};
      vecs[4] = '{1'b0, 5'd4,  8'h55, 1'b0, 32'h0000_0000, 8'h00};
      vecs[5] = '{1'b1, 5'd4,  8'h55, 1'b1, 32'h0000_0010, 8'h55};
      vecs[6] = '{1'b1, 5'd16, 8'hC3, 1'b1, 32'h0001_0000, 8'hC3};
      vecs[7] = '{1'b1, 5'd1,  8'h00, 1'b1, 32'h0000_0002, 8'h00};

      repeat (2) @(negedge clk);
      chk("rst_valid", 256'(ifa.valid_o), 0);
      chk("rst_data", ifa.data_o, 0);
      chk("rst_err", 256'(ifb.err_o), 0);
      chk("rst_cnt", 256'(ifb.drop_cnt_o), 0);
      chk("rst_busy", 256'(ifa.busy_o), 0);

      // back-to-back unicast beats; previous channel drains as the next loads
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ifa.en_i = vecs[i].en; ifa.sel_i = vecs[i].sel;
         ifa.data_i = vecs[i].data; ifa.valid_i = 1'b1;
         #1 chk($sformatf("vec%0d_ready", i), 256'(ifa.ready_o), 256'(vecs[i].exp_rdy));
         @(negedge clk);
         ed = 256'(vecs[i].exp_slice) << (32'(vecs[i].sel) * 8);
         chk($sformatf("vec%0d_valid", i), 256'(ifa.valid_o), 256'(vecs[i].exp_vld));
         chk($sformatf("vec%0d_data", i), ifa.data_o, ed);
      end
      ifa.valid_i = 1'b0; ifa.en_i = 1'b1;
      @(negedge clk);
      chk("idle_busy", 256'(ifa.busy_o), 0);

      // ch5 stall, second beat held off, then drain+load in one cycle
      ifa.ready_i = ~(32'h1 << 5);
      ifa.valid_i = 1'b1; ifa.sel_i = 5'd5; ifa.data_i = 8'h11;
      #1 chk("stall_rdy1", 256'(ifa.ready_o), 1);
      @(negedge clk);
      ifa.data_i = 8'h22;
      #1 chk("stall_rdy2", 256'(ifa.ready_o), 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("stall_hold", 256'(ifa.data_o[47:40]), 256'(8'h11));
         chk("stall_vld", 256'(ifa.valid_o[5]), 1);
         #1 chk("stall_rdy_lo", 256'(ifa.ready_o), 0);
      end
      ifa.ready_i = '1;
      #1 chk("stall_rdy_hi", 256'(ifa.ready_o), 1);
      @(negedge clk);
      ifa.valid_i = 1'b0;
      chk("stall_new", 256'(ifa.data_o[47:40]), 256'(8'h22));
      chk("stall_nobubble", 256'(ifa.valid_o), 256'(32'h20));
      @(negedge clk);
      chk("stall_empty", ifa.data_o, 0);

      // fill 0, 7, 19 stalled, then flush
      ifa.ready_i = ~(32'h1 | (32'h1 << 7) | (32'h1 << 19));
      ifa.valid_i = 1'b1;
      ifa.sel_i = 5'd0;  ifa.data_i = 8'h10; @(negedge clk);
      ifa.sel_i = 5'd7;  ifa.data_i = 8'h17; @(negedge clk);
      ifa.sel_i = 5'd19; ifa.data_i = 8'h29; @(negedge clk);
      ifa.sel_i = 5'd0;  ifa.flush_i = 1'b1;
      #1 chk("flush_rdy", 256'(ifa.ready_o), 0);
      chk("flush_pre", 256'(ifa.valid_o), 256'(32'h0008_0081));
      @(negedge clk);
      ifa.flush_i = 1'b0; ifa.valid_i = 1'b0;
      chk("flush_vld", 256'(ifa.valid_o), 0);
      chk("flush_data", ifa.data_o, 0);

      // disabled input lets a full slot drain
      ifa.ready_i = ~(32'h1 << 2);
      ifa.valid_i = 1'b1; ifa.sel_i = 5'd2; ifa.data_i = 8'hAB;
      @(negedge clk);
      ifa.en_i = 1'b0; ifa.data_i = 8'hCD; ifa.ready_i = '1;
      chk("en_busy_pre", 256'(ifa.busy_o), 1);
      #1 chk("en_rdy", 256'(ifa.ready_o), 0);
      @(negedge clk);
      ifa.valid_i = 1'b0; ifa.en_i = 1'b1;
      chk("en_drain", 256'(ifa.valid_o), 0);
      chk("en_busy", 256'(ifa.busy_o), 0);

`ifdef DEMUX_BCAST_EN
      ifa.ready_i = ~(32'h1 << 4);
      ifa.valid_i = 1'b1; ifa.sel_i = 5'd4; ifa.data_i = 8'h77;
      @(negedge clk);
      ifa.bcast_i = 1'b1; ifa.data_i = 8'h3C; ifa.sel_i = 5'd9;
      #1 chk("bc_rdy_lo", 256'(ifa.ready_o), 0);
      @(negedge clk);
      #1 chk("bc_rdy_lo2", 256'(ifa.ready_o), 0);
      ifa.ready_i = '1;
      #1 chk("bc_rdy_hi", 256'(ifa.ready_o), 1);
      @(negedge clk);
      ifa.valid_i = 1'b0; ifa.bcast_i = 1'b0;
      chk("bc_vld", 256'(ifa.valid_o), 256'(32'hFFFF_FFFF));
      chk("bc_data", ifa.data_o, {32{8'h3C}});
      @(negedge clk);
      chk("bc_drain", 256'(ifa.valid_o), 0);
`endif

      // out-of-range select on the 20-channel instance
      ifb.valid_i = 1'b1; ifb.sel_i = 5'd25;
      for (int k = 1; k <= 4; k++) begin
         ifb.data_i = 8'(k);
         #1 chk("drop_rdy", 256'(ifb.ready_o), 1);
         @(negedge clk);
         chk("drop_err", 256'(ifb.err_o), 1);
         chk("drop_cnt", 256'(ifb.drop_cnt_o), 256'((k > 3) ? 3 : k));
         chk("drop_novld", 256'(ifb.valid_o), 0);
      end
      ifb.valid_i = 1'b0;
      @(negedge clk);
      chk("drop_err_lo", 256'(ifb.err_o), 0);

      // random traffic against the channel-slot model
      for (int c = 0; c < 20; c++) begin mv[c] = 1'b0; md[c] = 8'h00; end
      mcnt = 3; merr = 1'b0;
      for (int n = 0; n < 400; n++) begin
         evv = '0; evd = '0;
         for (int c = 0; c < 20; c++) begin evv[c] = mv[c]; evd[c*8 +: 8] = md[c]; end
         chk("rnd_vld", 256'(ifb.valid_o), 256'(evv));
         chk("rnd_data", 256'(ifb.data_o), 256'(evd));
         chk("rnd_err", 256'(ifb.err_o), 256'(merr));
         chk("rnd_cnt", 256'(ifb.drop_cnt_o), 256'(mcnt));
         chk("rnd_busy", 256'(ifb.busy_o), 256'(|evv));
         r_en = ($urandom_range(0, 9) != 0);
         r_fl = ($urandom_range(0, 19) == 0);
         r_vl = ($urandom_range(0, 9) < 7);
         r_sel = 5'($urandom_range(0, 31));
         r_dat = 8'($urandom);
         r_rdy = 20'($urandom);
         ifb.en_i = r_en; ifb.flush_i = r_fl; ifb.valid_i = r_vl;
         ifb.sel_i = r_sel; ifb.data_i = r_dat; ifb.ready_i = r_rdy;
         if (r_fl || !r_en) exp_rdy = 1'b0;
         else if (r_sel >= 20) exp_rdy = 1'b1;
         else exp_rdy = !mv[r_sel] || r_rdy[r_sel];
         #1 chk("rnd_rdy", 256'(ifb.ready_o), 256'(exp_rdy));
         acc = r_vl && exp_rdy;
         for (int c = 0; c < 20; c++) begin
            if (r_fl) begin mv[c] = 1'b0; md[c] = 8'h00; end
            else if (acc && (int'(r_sel) == c)) begin mv[c] = 1'b1; md[c] = r_dat; end
            else if (mv[c] && r_rdy[c]) begin mv[c] = 1'b0; md[c] = 8'h00; end
         end
         merr = acc && (r_sel >= 20);
         if (merr && mcnt < 3) mcnt++;
         @(negedge clk);
      end
      ifb.valid_i = 1'b0; ifb.flush_i = 1'b0; ifb.en_i = 1'b1;

      // asynchronous reset while slots are full
      ifa.ready_i = '0; ifa.valid_i = 1'b1;
      ifa.sel_i = 5'd1; ifa.data_i = 8'h81; @(negedge clk);
      ifa.sel_i = 5'd9; ifa.data_i = 8'h89; @(negedge clk);
      ifa.valid_i = 1'b0;
      chk("ar_busy_pre", 256'(ifa.busy_o), 1);
      #2 rst_n = 1'b0;
      #1 chk("ar_vld", 256'(ifa.valid_o), 0);
      chk("ar_data", ifa.data_o, 0);
      chk("ar_busy", 256'(ifa.busy_o), 0);
      chk("ar_cnt", 256'(ifb.drop_cnt_o), 0);
      @(negedge clk);
      rst_n = 1'b1; ifa.ready_i = '1;
      ifa.valid_i = 1'b1; ifa.sel_i = 5'd6; ifa.data_i = 8'h66;
      @(negedge clk);
      ifa.valid_i = 1'b0;
      chk("ar_first", 256'(ifa.valid_o), 256'(32'h40));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
